// File: rtl/acc_ctrl_pkg.sv
// Shared constants for the accumulator-processor control FSM: opcodes, ALU codes,
// mux-select names and the 4-bit state encoding (S_HALT exists only with ACC_CTRL_HALT_EN).
package acc_ctrl_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_NOT = 3'b011;
    localparam logic [2:0] OP_LDA = 3'b100;
    localparam logic [2:0] OP_STA = 3'b101;
    localparam logic [2:0] OP_JMP = 3'b110;
    localparam logic [2:0] OP_JZ  = 3'b111;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_AND  = 2'b10;
    localparam logic [1:0] ALU_NOTB = 2'b11;

    // Datapath muxes pick in1 when their select is low.
    localparam logic SEL_IN1 = 1'b0;
    localparam logic SEL_IN2 = 1'b1;

    typedef enum logic [3:0] {
        S_INIT   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMRD  = 4'd3,
        S_OPLOAD = 4'd4,
        S_ALU_EX = 4'd5,
        S_ALU_WB = 4'd6,
        S_LDA_WB = 4'd7,
        S_MEMWR  = 4'd8
`ifdef ACC_CTRL_HALT_EN
        , S_HALT = 4'd9
`endif
    } state_t;

endpackage

// File: rtl/mem_wait_counter.sv
// Memory-access wait counter: done flags the last cycle of a MEM_LAT-cycle access.
// Saturates at MEM_LAT-1 so it can never wrap while a state is held.
module mem_wait_counter #(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    output logic done
);

    logic [CNT_W-1:0] r_cnt;

    assign done = (r_cnt == CNT_W'(MEM_LAT - 1));

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
        end else if (clear) begin
            r_cnt <= '0;
        end else if (!done) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/acc_controller.sv
// Multi-cycle Moore control FSM for the 16-bit accumulator processor.
// Optional halt support (halt_req/halted ports, S_HALT state) under `ACC_CTRL_HALT_EN.
module acc_controller
    import acc_ctrl_pkg::*;
#(
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] opcode,
    input  logic       zero,
`ifdef ACC_CTRL_HALT_EN
    input  logic       halt_req,
    output logic       halted,
`endif
    output logic       PC_init,
    output logic       PCwrite,
    output logic       PCwrite_cond,
    output logic       PCsrc,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRwrite,
    output logic       ldACC,
    output logic       ACCsrc,
    output logic       ldA,
    output logic       ldB,
    output logic       Asrc,
    output logic       Bsrc,
    output logic [1:0] ALUop
);

    state_t r_state;
    state_t w_next;
    state_t w_to_fetch;
    logic   w_done;
    logic   w_clear;
    logic   w_unused_zero;

    // Branch resolution lives in the datapath PC unit; zero is deliberately ignored here.
    assign w_unused_zero = zero;

`ifdef ACC_CTRL_HALT_EN
    assign w_to_fetch = halt_req ? S_HALT : S_FETCH;
`else
    assign w_to_fetch = S_FETCH;
`endif

    // Any state change restarts the wait count, so every access state starts at 0.
    assign w_clear = (w_next != r_state);

    mem_wait_counter #(
        .MEM_LAT (MEM_LAT),
        .CNT_W   (CNT_W)
    ) u_wait (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (w_clear),
        .done  (w_done)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_INIT;
        end else begin
            r_state <= w_next;
        end
    end

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_INIT:   w_next = w_to_fetch;
            S_FETCH:  if (w_done) w_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_ADD, OP_SUB, OP_AND, OP_LDA: w_next = S_MEMRD;
                    OP_NOT:                         w_next = S_ALU_EX;
                    OP_STA:                         w_next = S_MEMWR;
                    default:                        w_next = w_to_fetch;
                endcase
            end
            S_MEMRD:  if (w_done) w_next = (opcode == OP_LDA) ? S_LDA_WB : S_OPLOAD;
            S_OPLOAD: w_next = S_ALU_EX;
            S_ALU_EX: w_next = S_ALU_WB;
            S_ALU_WB: w_next = w_to_fetch;
            S_LDA_WB: w_next = w_to_fetch;
            S_MEMWR:  if (w_done) w_next = w_to_fetch;
`ifdef ACC_CTRL_HALT_EN
            S_HALT:   if (!halt_req) w_next = S_FETCH;
`endif
            default:  w_next = S_INIT;
        endcase
    end

    always_comb begin
        PC_init      = 1'b0;
        PCwrite      = 1'b0;
        PCwrite_cond = 1'b0;
        PCsrc        = SEL_IN1;
        IorD         = SEL_IN1;
        MemRead      = 1'b0;
        MemWrite     = 1'b0;
        IRwrite      = 1'b0;
        ldACC        = 1'b0;
        ACCsrc       = SEL_IN1;
        ldA          = 1'b0;
        ldB          = 1'b0;
        Asrc         = SEL_IN1;
        Bsrc         = SEL_IN1;
        ALUop        = ALU_ADD;
`ifdef ACC_CTRL_HALT_EN
        halted       = 1'b0;
`endif
        case (r_state)
            S_INIT: PC_init = 1'b1;
            S_FETCH: begin
                IorD    = SEL_IN1;
                MemRead = 1'b1;
                // PC+1 and IR load happen only on the final wait cycle: one increment per fetch.
                if (w_done) begin
                    IRwrite = 1'b1;
                    Asrc    = SEL_IN2;
                    Bsrc    = SEL_IN2;
                    ALUop   = ALU_ADD;
                    PCsrc   = SEL_IN1;
                    PCwrite = 1'b1;
                end
            end
            S_DECODE: begin
                if (opcode == OP_JMP) begin
                    PCsrc   = SEL_IN2;
                    PCwrite = 1'b1;
                end else if (opcode == OP_JZ) begin
                    PCsrc        = SEL_IN2;
                    PCwrite_cond = 1'b1;
                end
            end
            S_MEMRD: begin
                IorD    = SEL_IN2;
                MemRead = 1'b1;
            end
            S_OPLOAD: begin
                ldA = 1'b1;
                ldB = 1'b1;
            end
            S_ALU_EX: begin
                Asrc  = SEL_IN1;
                Bsrc  = SEL_IN1;
                ALUop = opcode[1:0];
            end
            S_ALU_WB: begin
                ACCsrc = SEL_IN1;
                ldACC  = 1'b1;
            end
            S_LDA_WB: begin
                ACCsrc = SEL_IN2;
                ldACC  = 1'b1;
            end
            S_MEMWR: begin
                IorD     = SEL_IN2;
                MemWrite = 1'b1;
            end
`ifdef ACC_CTRL_HALT_EN
            S_HALT: halted = 1'b1;
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_acc_controller.sv
// Scoreboard bench for acc_controller: one instance with MEM_LAT=1, one with MEM_LAT=3.
// Expected per-cycle strobe vectors are queued per instruction and popped each cycle.
module tb_acc_controller;
    import acc_ctrl_pkg::*;

    typedef struct packed {
        logic       pc_init;
        logic       pcwrite;
        logic       pcwrite_cond;
        logic       pcsrc;
        logic       iord;
        logic       memread;
        logic       memwrite;
        logic       irwrite;
        logic       ldacc;
        logic       accsrc;
        logic       lda;
        logic       ldb;
        logic       asrc;
        logic       bsrc;
        logic [1:0] aluop;
    } strobes_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [2:0] opcode = OP_ADD;
    logic       zero = 1'b0;
    wire [15:0] o1;
    wire [15:0] o3;
`ifdef ACC_CTRL_HALT_EN
    logic       halt_req = 1'b0;
    wire        halted1;
    wire        halted3;
`endif

    int n_vec = 0;
    int n_err = 0;
    strobes_t exp_q[$];

    always #5 clk = ~clk;

    acc_controller #(.MEM_LAT(1), .CNT_W(4)) dut1 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
`ifdef ACC_CTRL_HALT_EN
        .halt_req(halt_req), .halted(halted1),
`endif
        .PC_init(o1[15]), .PCwrite(o1[14]), .PCwrite_cond(o1[13]), .PCsrc(o1[12]),
        .IorD(o1[11]), .MemRead(o1[10]), .MemWrite(o1[9]), .IRwrite(o1[8]),
        .ldACC(o1[7]), .ACCsrc(o1[6]), .ldA(o1[5]), .ldB(o1[4]),
        .Asrc(o1[3]), .Bsrc(o1[2]), .ALUop(o1[1:0])
    );

    acc_controller #(.MEM_LAT(3), .CNT_W(4)) dut3 (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero),
`ifdef ACC_CTRL_HALT_EN
        .halt_req(halt_req), .halted(halted3),
`endif
        .PC_init(o3[15]), .PCwrite(o3[14]), .PCwrite_cond(o3[13]), .PCsrc(o3[12]),
        .IorD(o3[11]), .MemRead(o3[10]), .MemWrite(o3[9]), .IRwrite(o3[8]),
        .ldACC(o3[7]), .ACCsrc(o3[6]), .ldA(o3[5]), .ldB(o3[4]),
        .Asrc(o3[3]), .Bsrc(o3[2]), .ALUop(o3[1:0])
    );

    // Reference sequence for one instruction, starting at its first FETCH cycle.
    task automatic push_instr(input logic [2:0] op, input int lat);
        strobes_t s;
        for (int i = 0; i < lat; i++) begin
            s = '0;
            s.memread = 1'b1;
            if (i == lat - 1) begin
                s.irwrite = 1'b1;
                s.asrc    = 1'b1;
                s.bsrc    = 1'b1;
                s.pcwrite = 1'b1;
            end
            exp_q.push_back(s);
        end
        s = '0;
        if (op == OP_JMP) begin s.pcsrc = 1'b1; s.pcwrite = 1'b1; end
        if (op == OP_JZ)  begin s.pcsrc = 1'b1; s.pcwrite_cond = 1'b1; end
        exp_q.push_back(s);
        if (op inside {OP_ADD, OP_SUB, OP_AND, OP_LDA}) begin
            for (int i = 0; i < lat; i++) begin
                s = '0; s.iord = 1'b1; s.memread = 1'b1;
                exp_q.push_back(s);
            end
        end
        if (op == OP_LDA) begin
            s = '0; s.accsrc = 1'b1; s.ldacc = 1'b1;
            exp_q.push_back(s);
        end
        if (op inside {OP_ADD, OP_SUB, OP_AND}) begin
            s = '0; s.lda = 1'b1; s.ldb = 1'b1;
            exp_q.push_back(s);
        end
        if (op inside {OP_ADD, OP_SUB, OP_AND, OP_NOT}) begin
            s = '0; s.aluop = op[1:0];
            exp_q.push_back(s);
            s = '0; s.ldacc = 1'b1;
            exp_q.push_back(s);
        end
        if (op == OP_STA) begin
            for (int i = 0; i < lat; i++) begin
                s = '0; s.iord = 1'b1; s.memwrite = 1'b1;
                exp_q.push_back(s);
            end
        end
    endtask

    // Runs one instruction on the chosen instance; opcode changes once FETCH is entered.
    task automatic exec(input logic [2:0] op, input bit slow, input int halt_at, input string tag);
        strobes_t e;
        strobes_t got;
        int n = 0;
        push_instr(op, slow ? 3 : 1);
        while (exp_q.size() > 0) begin
            @(posedge clk); #1;
            if (n == 0) opcode = op;
`ifdef ACC_CTRL_HALT_EN
            if (n == halt_at) halt_req = 1'b1;
`endif
            e   = exp_q.pop_front();
            got = slow ? o3 : o1;
            n_vec++;
            if (got !== e) begin
                n_err++;
                $display("FAIL %s cycle %0d: strobes got %h, expected %h", tag, n, got, e);
            end
            n++;
        end
    endtask

    task automatic do_reset();
        strobes_t s;
        s = '0;
        s.pc_init = 1'b1;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_vec++;
        if (o1 !== s || o3 !== s) begin
            n_err++;
            $display("FAIL reset_hold: strobes got %h/%h, expected %h", o1, o3, s);
        end
`ifdef ACC_CTRL_HALT_EN
        n_vec++;
        if (halted1 !== 1'b0) begin
            n_err++;
            $display("FAIL reset_halted: got %b, expected 0", halted1);
        end
`endif
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        n_vec++;
        if (o1 !== s || o3 !== s) begin
            n_err++;
            $display("FAIL reset_init: strobes got %h/%h, expected %h", o1, o3, s);
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        strobes_t s;
        do_reset();
        opcode = OP_ADD;
        repeat (3) begin @(posedge clk); #1; end
        s = '0; s.iord = 1'b1; s.memread = 1'b1;
        n_vec++;
        if (o1 !== s) begin
            n_err++;
            $display("FAIL reset_pre_memrd: strobes got %h, expected %h", o1, s);
        end
        #2 rst_n = 1'b0;
        #1;
        s = '0; s.pc_init = 1'b1;
        n_vec++;
        if (o1 !== s) begin
            n_err++;
            $display("FAIL reset_mid_memrd: strobes got %h, expected %h", o1, s);
        end
        do_reset();
        exec(OP_ADD, 1'b0, -1, "reset_then_add");
    endtask

    task automatic test_alu_ops();
        do_reset();
        exec(OP_ADD, 1'b0, -1, "add");
        exec(OP_SUB, 1'b0, -1, "sub");
        exec(OP_AND, 1'b0, -1, "and");
        exec(OP_NOT, 1'b0, -1, "not");
    endtask

    task automatic test_branches();
        exec(OP_JMP, 1'b0, -1, "jmp");
        zero = 1'b0;
        exec(OP_JZ, 1'b0, -1, "jz_zero0");
        zero = 1'b1;
        exec(OP_JZ, 1'b0, -1, "jz_zero1");
        exec(OP_NOT, 1'b0, -1, "after_jz");
        zero = 1'b0;
    endtask

    task automatic test_load_store();
        exec(OP_LDA, 1'b0, -1, "lda");
        exec(OP_STA, 1'b0, -1, "sta");
        exec(OP_LDA, 1'b0, -1, "lda_after_sta");
    endtask

    task automatic test_slow_mem();
        do_reset();
        exec(OP_STA, 1'b1, -1, "sta_lat3");
        exec(OP_LDA, 1'b1, -1, "lda_lat3");
        exec(OP_ADD, 1'b1, -1, "add_lat3");
        exec(OP_JZ,  1'b1, -1, "jz_lat3");
        exec(OP_STA, 1'b1, -1, "sta_lat3_again");
    endtask

    task automatic test_back_to_back();
        logic [2:0] op;
        do_reset();
        for (int i = 0; i < 24; i++) begin
            op   = 3'($urandom_range(0, 7));
            zero = 1'($urandom_range(0, 1));
            exec(op, 1'b0, -1, "b2b");
        end
    endtask

`ifdef ACC_CTRL_HALT_EN
    task automatic test_halt();
        do_reset();
        halt_req = 1'b0;
        exec(OP_ADD, 1'b0, 2, "add_then_halt");
        repeat (2) begin
            @(posedge clk); #1;
            n_vec++;
            if (o1 !== 16'h0000 || halted1 !== 1'b1) begin
                n_err++;
                $display("FAIL halt_state: strobes got %h halted %b, expected 0000 halted 1", o1, halted1);
            end
        end
        halt_req = 1'b0;
        exec(OP_JMP, 1'b0, -1, "resume_fetch");
        n_vec++;
        if (halted1 !== 1'b0) begin
            n_err++;
            $display("FAIL halt_release: halted got %b, expected 0", halted1);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_alu_ops();
        test_branches();
        test_load_store();
        test_slow_mem();
        test_back_to_back();
`ifdef ACC_CTRL_HALT_EN
        test_halt();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
